fma_sequencer: RTL and testbench

Command-driven initiator for the vector lane's multiply/add datapath. Accepts one vector command (add, sub, elementwise multiply, or dot product), streams element pairs from the vector register file read port into the datapath one per cycle, and drives `use_fma`/`fma_first` so the datapath's unenabled accumulator register is seeded and chained correctly. Elementwise results go to the register-file write port; the dot-product result is returned on a valid/ready result port.

---
 rtl/fma_seq_pkg.sv | 28 ++
 rtl/fma_sequencer_if.sv | 46 ++++
 rtl/fma_seq_pipe.sv | 48 ++++
 rtl/fma_sequencer.sv | 106 ++++++++++
 tb/tb_fma_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fma_seq_pkg.sv
// Shared types and width helpers for the FMA command sequencer.
package fma_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DOT = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Width of an element index (at least one bit).
   function automatic int idx_w(input int els);
      return (els > 1) ? $clog2(els) : 1;
   endfunction

   // Width of an element count, which must be able to hold els itself.
   function automatic int len_w(input int els);
      return $clog2(els + 1);
   endfunction

endpackage

// File: rtl/fma_sequencer_if.sv
// Command, register-file, datapath and result signals of the sequencer.
interface fma_sequencer_if
   import fma_seq_pkg::*;
#(
   parameter int vdw_p = 32,
   parameter int els_p = 16
);
   localparam int lw_lp = len_w(els_p);
   localparam int iw_lp = idx_w(els_p);

   logic             cmd_v_i;
   logic             cmd_ready_o;
   logic [1:0]       cmd_op_i;
   logic [lw_lp-1:0] cmd_len_i;
   logic             rd_v_o;
   logic [iw_lp-1:0] rd_addr_o;
   logic [vdw_p-1:0] rd_a_i;
   logic [vdw_p-1:0] rd_b_i;
   logic [vdw_p-1:0] a_o;
   logic [vdw_p-1:0] b_o;
   logic [1:0]       alu_op_o;
   logic             use_fma_o;
   logic             fma_first_o;
   logic [vdw_p-1:0] data_i;
   logic             wr_v_o;
   logic [iw_lp-1:0] wr_addr_o;
   logic [vdw_p-1:0] wr_data_o;
   logic             res_v_o;
   logic             res_ready_i;
   logic [vdw_p-1:0] res_data_o;

   // Sequencer side.
   modport master (
      input  cmd_v_i, cmd_op_i, cmd_len_i, rd_a_i, rd_b_i, data_i, res_ready_i,
      output cmd_ready_o, rd_v_o, rd_addr_o, a_o, b_o, alu_op_o, use_fma_o,
             fma_first_o, wr_v_o, wr_addr_o, wr_data_o, res_v_o, res_data_o
   );

   // Command source / register file / datapath side.
   modport slave (
      output cmd_v_i, cmd_op_i, cmd_len_i, rd_a_i, rd_b_i, data_i, res_ready_i,
      input  cmd_ready_o, rd_v_o, rd_addr_o, a_o, b_o, alu_op_o, use_fma_o,
             fma_first_o, wr_v_o, wr_addr_o, wr_data_o, res_v_o, res_data_o
   );

endinterface

// File: rtl/fma_seq_pipe.sv
// Two-stage control pipe: stage 1 is the datapath-drive cycle (read data
// present), stage 2 is the cycle the datapath result appears on data_i.
module fma_seq_pipe
   import fma_seq_pkg::*;
#(
   parameter int iw_p = 4
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  logic            in_v_i,
   input  logic [iw_p-1:0] in_idx_i,
   input  logic            in_first_i,
   input  logic            in_last_i,
   output logic            s1_v_o,
   output logic            s1_first_o,
   output logic            s2_v_o,
   output logic [iw_p-1:0] s2_idx_o,
   output logic            s2_last_o
);
   localparam int stages_lp = 2;

   logic [stages_lp:1]           vld_pipe;
   logic [stages_lp:1][iw_p-1:0] idx_pipe;
   logic [stages_lp:1]           last_pipe;
   logic                         first_s1;

   // Shift issue-cycle tags forward one stage per clock; reset drops all valids.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         vld_pipe  <= '0;
         idx_pipe  <= '0;
         last_pipe <= '0;
         first_s1  <= 1'b0;
      end else begin
         vld_pipe  <= {vld_pipe[1], in_v_i};
         idx_pipe  <= {idx_pipe[1], in_idx_i};
         last_pipe <= {last_pipe[1], in_last_i};
         first_s1  <= in_v_i & in_first_i;
      end
   end

   assign s1_v_o     = vld_pipe[1];
   assign s1_first_o = vld_pipe[1] & first_s1;
   assign s2_v_o     = vld_pipe[2];
   assign s2_idx_o   = idx_pipe[2];
   assign s2_last_o  = vld_pipe[2] & last_pipe[2];

endmodule

// File: rtl/fma_sequencer.sv
// Vector command sequencer: streams element pairs through the multiply/add
// datapath, writes elementwise results back and returns dot results.
module fma_sequencer
   import fma_seq_pkg::*;
#(
   parameter int vdw_p = 32,
   parameter int els_p = 16
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   fma_sequencer_if.master io
);
   localparam int lw_lp = len_w(els_p);
   localparam int iw_lp = idx_w(els_p);

   state_e           state_q, state_d;
   op_e              op_q;
   logic [lw_lp-1:0] len_q;
   logic [iw_lp-1:0] cnt_q;
   logic [vdw_p-1:0] res_q;
   logic [lw_lp-1:0] len_clamp;
   logic             issue, last_issue;
   logic             s1_v, s1_first, s2_v, s2_last;
   logic [iw_lp-1:0] s2_idx;
   logic             is_dot;

   assign len_clamp  = (io.cmd_len_i > lw_lp'(els_p)) ? lw_lp'(els_p) : io.cmd_len_i;
   assign issue      = (state_q == ST_RUN);
   assign last_issue = issue && ((lw_lp'(cnt_q) + lw_lp'(1)) == len_q);
   assign is_dot     = (op_q == OP_DOT);

   fma_seq_pipe #(.iw_p(iw_lp)) u_pipe (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .in_v_i     (issue),
      .in_idx_i   (cnt_q),
      .in_first_i (cnt_q == '0),
      .in_last_i  (last_issue),
      .s1_v_o     (s1_v),
      .s1_first_o (s1_first),
      .s2_v_o     (s2_v),
      .s2_idx_o   (s2_idx),
      .s2_last_o  (s2_last)
   );

   // State, latched command, issue counter and dot result register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         op_q    <= OP_ADD;
         len_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && io.cmd_v_i) begin
            op_q  <= op_e'(io.cmd_op_i);
            len_q <= len_clamp;
            cnt_q <= '0;
            res_q <= '0;
         end
         if (issue) cnt_q <= cnt_q + iw_lp'(1);
         // The last dot element's accumulated value is the command result.
         if (s2_last && is_dot) res_q <= io.data_i;
      end
   end

   // Next state plus all handshake and datapath outputs.
   always_comb begin
      state_d        = state_q;
      io.cmd_ready_o = 1'b0;
      io.rd_v_o      = issue;
      io.rd_addr_o   = issue ? cnt_q : '0;
      io.a_o         = s1_v ? io.rd_a_i : '0;
      io.b_o         = s1_v ? io.rd_b_i : '0;
      io.alu_op_o    = s1_v ? op_q : 2'b00;
      io.use_fma_o   = s1_v && is_dot;
      io.fma_first_o = s1_first && is_dot;
      io.wr_v_o      = s2_v && !is_dot;
      io.wr_addr_o   = (s2_v && !is_dot) ? s2_idx : '0;
      io.wr_data_o   = (s2_v && !is_dot) ? io.data_i : '0;
      io.res_v_o     = 1'b0;
      io.res_data_o  = '0;
      case (state_q)
         ST_IDLE: begin
            // Ready is held low while reset is asserted so every output reads 0.
            io.cmd_ready_o = reset_n_i;
            if (io.cmd_v_i) state_d = (len_clamp == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (last_issue) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Once S1 is empty, S2 empties (and the result lands) this cycle.
            if (!s1_v) state_d = ST_DONE;
         end
         ST_DONE: begin
            io.res_v_o    = 1'b1;
            io.res_data_o = res_q;
            if (io.res_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fma_sequencer.sv
// Directed and random command bench for fma_sequencer with register-file and
// datapath models; expectations come from plain arithmetic on the operands.
module tb_fma_sequencer;
   import fma_seq_pkg::*;

   localparam int VDW = 32;
   localparam int ELS = 16;

   logic clk_i = 1'b0;
   logic reset_n_i = 1'b0;
   always #5 clk_i = ~clk_i;

   fma_sequencer_if #(.vdw_p(VDW), .els_p(ELS)) io ();

   fma_sequencer #(.vdw_p(VDW), .els_p(ELS)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .io        (io)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_a [ELS];
   logic [31:0] mem_b [ELS];
   logic [31:0] acc;
   logic [31:0] dp_nxt;

   // Register file: operands appear the cycle after the read request.
   always @(posedge clk_i) begin
      if (io.rd_v_o) begin
         io.rd_a_i <= mem_a[io.rd_addr_o];
         io.rd_b_i <= mem_b[io.rd_addr_o];
      end
   end

   // Datapath result for the current drive cycle.
   always_comb begin
      dp_nxt = '0;
      if (io.use_fma_o) dp_nxt = (io.fma_first_o ? 32'd0 : acc) + io.a_o * io.b_o;
      else begin
         case (io.alu_op_o)
            2'b00:   dp_nxt = io.a_o + io.b_o;
            2'b01:   dp_nxt = io.a_o - io.b_o;
            default: dp_nxt = io.a_o * io.b_o;
         endcase
      end
   end

   // Registered datapath output and its free-running accumulator.
   always @(posedge clk_i) begin
      io.data_i <= dp_nxt;
      if (io.use_fma_o) acc <= dp_nxt;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_elem(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         default: return a * b;
      endcase
   endfunction

   function automatic logic [31:0] ref_dot(input int n);
      logic [31:0] s;
      s = 0;
      for (int i = 0; i < n; i++) s = s + mem_a[i] * mem_b[i];
      return s;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < ELS; i++) begin
         mem_a[i] = $urandom;
         mem_b[i] = $urandom;
      end
   endtask

   // Issue one command and check every cycle up to and through the result handshake.
   task automatic run_cmd(input logic [1:0] op, input int len, input int hold);
      int          n, r;
      logic        dot, drv, wr;
      logic [31:0] exp_res;
      n       = (len > ELS) ? ELS : len;
      dot     = (op == 2'b11);
      exp_res = dot ? ref_dot(n) : 32'd0;
      r       = (n == 0) ? 1 : n + 3;
      @(negedge clk_i);
      chk("cmd_ready_idle", io.cmd_ready_o, 1);
      io.cmd_v_i   = 1'b1;
      io.cmd_op_i  = op;
      io.cmd_len_i = 5'(len);
      @(posedge clk_i);
      #1 io.cmd_v_i = 1'b0;
      for (int k = 1; k <= r; k++) begin
         @(negedge clk_i);
         drv = (k >= 2) && (k <= n + 1);
         wr  = !dot && (k >= 3) && (k <= n + 2);
         chk("rd_v", io.rd_v_o, (k <= n));
         if (k <= n) chk("rd_addr", io.rd_addr_o, k - 1);
         chk("use_fma", io.use_fma_o, dot && drv);
         chk("fma_first", io.fma_first_o, dot && (k == 2));
         if (drv) begin
            chk("a_o", io.a_o, mem_a[k-2]);
            chk("b_o", io.b_o, mem_b[k-2]);
            chk("alu_op", io.alu_op_o, op);
         end
         chk("wr_v", io.wr_v_o, wr);
         if (wr) begin
            chk("wr_addr", io.wr_addr_o, k - 3);
            chk("wr_data", io.wr_data_o, ref_elem(op, mem_a[k-3], mem_b[k-3]));
         end
         chk("res_v", io.res_v_o, (k == r));
         chk("cmd_ready_busy", io.cmd_ready_o, 0);
      end
      chk("res_data", io.res_data_o, exp_res);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_i);
         chk("res_v_hold", io.res_v_o, 1);
         chk("res_data_hold", io.res_data_o, exp_res);
         chk("cmd_ready_hold", io.cmd_ready_o, 0);
      end
      io.res_ready_i = 1'b1;
      @(posedge clk_i);
      #1 io.res_ready_i = 1'b0;
      @(negedge clk_i);
      chk("cmd_ready_after", io.cmd_ready_o, 1);
      chk("res_v_after", io.res_v_o, 0);
   endtask

   initial begin
      io.cmd_v_i     = 1'b0;
      io.cmd_op_i    = 2'b00;
      io.cmd_len_i   = '0;
      io.res_ready_i = 1'b0;
      for (int i = 0; i < ELS; i++) begin
         mem_a[i] = 0;
         mem_b[i] = 0;
      end

      // Outputs while held in reset, then ready after release.
      repeat (2) @(negedge clk_i);
      chk("rst_cmd_ready", io.cmd_ready_o, 0);
      chk("rst_rd_v", io.rd_v_o, 0);
      chk("rst_wr_v", io.wr_v_o, 0);
      chk("rst_res_v", io.res_v_o, 0);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      chk("post_rst_ready", io.cmd_ready_o, 1);
      chk("post_rst_res_v", io.res_v_o, 0);

      // Dot of {1,2,3,4}.{5,6,7,8} = 70.
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = i + 1;
         mem_b[i] = i + 5;
      end
      run_cmd(2'b11, 4, 0);

      // Add with a wrapping element.
      mem_a[0] = 10; mem_a[1] = 20; mem_a[2] = 32'hFFFF_FFFF;
      mem_b[0] = 1;  mem_b[1] = 2;  mem_b[2] = 1;
      run_cmd(2'b00, 3, 0);

      // Back-to-back dots: 3*3+4*4 then 2*5.
      mem_a[0] = 3; mem_b[0] = 3; mem_a[1] = 4; mem_b[1] = 4;
      run_cmd(2'b11, 2, 0);
      mem_a[0] = 2; mem_b[0] = 5;
      run_cmd(2'b11, 1, 0);

      // Zero length, then an over-long length that clamps to ELS.
      run_cmd(2'b10, 0, 0);
      fill_random();
      run_cmd(2'b00, 20, 0);

      // Result held through five cycles of backpressure.
      fill_random();
      run_cmd(2'b01, 6, 5);

      // Random ops, lengths, data and backpressure.
      for (int t = 0; t < 10; t++) begin
         fill_random();
         run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 20), $urandom_range(0, 3));
      end

      // Reset during cycle T+3 of a len=8 mul.
      fill_random();
      @(negedge clk_i);
      io.cmd_v_i   = 1'b1;
      io.cmd_op_i  = 2'b10;
      io.cmd_len_i = 5'd8;
      @(posedge clk_i);
      #1 io.cmd_v_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2 reset_n_i = 1'b0;
      #1;
      chk("mid_rst_cmd_ready", io.cmd_ready_o, 0);
      chk("mid_rst_rd_v", io.rd_v_o, 0);
      chk("mid_rst_rd_addr", io.rd_addr_o, 0);
      chk("mid_rst_a", io.a_o, 0);
      chk("mid_rst_b", io.b_o, 0);
      chk("mid_rst_alu_op", io.alu_op_o, 0);
      chk("mid_rst_use_fma", io.use_fma_o, 0);
      chk("mid_rst_fma_first", io.fma_first_o, 0);
      chk("mid_rst_wr_v", io.wr_v_o, 0);
      chk("mid_rst_wr_data", io.wr_data_o, 0);
      chk("mid_rst_res_v", io.res_v_o, 0);
      chk("mid_rst_res_data", io.res_data_o, 0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_i);
         chk("after_rst_wr_v", io.wr_v_o, 0);
         chk("after_rst_res_v", io.res_v_o, 0);
         chk("after_rst_rd_v", io.rd_v_o, 0);
         chk("after_rst_ready", io.cmd_ready_o, 1);
      end

      // Normal operation resumes after the abort.
      fill_random();
      run_cmd(2'b11, 3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
